univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 117 +++++++++++
 tb/tb_univ_shift_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : Universal shift register with hold, shift right, shift left and
//            parallel load, plus a frame counter that pulses frame_done once
//            every WIDTH shifts (left and right shifts both count).
// Ports    : clk        - clock, all state updates on rising edge
//            rst        - synchronous reset, active low
//            en         - clock enable, 0 freezes register and counter
//            mode[1:0]  - 00 hold, 01 shift right, 10 shift left, 11 load
//            sin_r      - serial in for right shift (enters MSB)
//            sin_l      - serial in for left shift (enters LSB)
//            pin        - parallel load data
//            pout       - register contents
//            sout_r     - q[0], serial out for right shift
//            sout_l     - q[WIDTH-1], serial out for left shift
//            frame_done - registered one-cycle pulse after WIDTH shifts
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
  parameter int WIDTH = 8,
  // Derived from WIDTH; do not override.
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             frame_done
);

  localparam logic [1:0]       c_mode_hold  = 2'b00;
  localparam logic [1:0]       c_mode_right = 2'b01;
  localparam logic [1:0]       c_mode_left  = 2'b10;
  localparam logic [1:0]       c_mode_load  = 2'b11;
  localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_done;

  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done_next;
  logic             w_advance;

  // Next-state decode. frame_done defaults low so it can only ever be a
  // single-cycle pulse; it is raised solely by a shift that wraps the counter.
  always_comb begin
    w_q_next    = r_q;
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    w_advance   = 1'b0;

    if (en) begin
      case (mode)
        c_mode_hold: begin
          w_q_next = r_q;
        end
        c_mode_right: begin
          w_q_next  = {sin_r, r_q[WIDTH-1:1]};
          w_advance = 1'b1;
        end
        c_mode_left: begin
          w_q_next  = {r_q[WIDTH-2:0], sin_l};
          w_advance = 1'b1;
        end
        c_mode_load: begin
          // A load always restarts the frame, even if the counter was about
          // to wrap, so no pulse is produced on a load edge.
          w_q_next   = pin;
          w_cnt_next = '0;
        end
        default: begin
          w_q_next = r_q;
        end
      endcase

      // Both shift directions share one counter; holds and disabled cycles
      // in between leave it untouched so a frame may span gaps.
      if (w_advance) begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_next  = '0;
          w_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q          <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_q          <= w_q_next;
      r_cnt        <= w_cnt_next;
      r_frame_done <= w_done_next;
    end
  end

  // Serial outputs are plain taps of the register: no added latency.
  assign pout       = r_q;
  assign sout_r     = r_q[0];
  assign sout_l     = r_q[WIDTH-1];
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Self-checking bench for univ_shift_reg. A WIDTH=4 instance is
//            driven with directed steps whose expected results are written
//            out literally; a WIDTH=8 instance is driven with random stimulus
//            and compared against a behavioural reference model. Expected
//            results are queued when stimulus is applied and popped/compared
//            one time unit after the following rising edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance signals
  logic       rst4, en4, sin_r4, sin_l4;
  logic [1:0] mode4;
  logic [3:0] pin4, pout4;
  logic       sout_r4, sout_l4, fd4;

  // WIDTH=8 instance signals
  logic       rst8, en8, sin_r8, sin_l8;
  logic [1:0] mode8;
  logic [7:0] pin8, pout8;
  logic       sout_r8, sout_l8, fd8;

  univ_shift_reg #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst4),
    .en         (en4),
    .mode       (mode4),
    .sin_r      (sin_r4),
    .sin_l      (sin_l4),
    .pin        (pin4),
    .pout       (pout4),
    .sout_r     (sout_r4),
    .sout_l     (sout_l4),
    .frame_done (fd4)
  );

  univ_shift_reg #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst8),
    .en         (en8),
    .mode       (mode8),
    .sin_r      (sin_r8),
    .sin_l      (sin_l8),
    .pin        (pin8),
    .pout       (pout8),
    .sout_r     (sout_r8),
    .sout_l     (sout_l8),
    .frame_done (fd8)
  );

  // Scoreboard queues: {pout, sout_r, sout_l, frame_done}
  logic [6:0]  exp4_q[$];
  logic [10:0] exp8_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state for the WIDTH=8 instance
  logic [7:0] m_q;
  int         m_cnt;
  logic       m_fd;

  task automatic check(input string tag, input logic [10:0] obs,
                       input logic [10:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One directed step on the WIDTH=4 instance with literal expectations.
  task automatic step4(input string tag, input logic r, input logic e,
                       input logic [1:0] md, input logic sr, input logic sl,
                       input logic [3:0] p, input logic [3:0] ep,
                       input logic ef);
    logic [6:0] got;
    rst4 = r; en4 = e; mode4 = md; sin_r4 = sr; sin_l4 = sl; pin4 = p;
    exp4_q.push_back({ep, ep[0], ep[3], ef});
    @(posedge clk);
    #1;
    if (exp4_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: observed=empty-queue expected=entry", tag);
    end else begin
      got = exp4_q.pop_front();
      check(tag, {4'b0, pout4, sout_r4, sout_l4, fd4}, {4'b0, got});
    end
  endtask

  // Behavioural model of the WIDTH=8 register for one edge.
  task automatic model8(input logic r, input logic e, input logic [1:0] md,
                        input logic sr, input logic sl, input logic [7:0] p);
    bit adv;
    adv = 1'b0;
    if (!r) begin
      m_q = 8'h00; m_cnt = 0; m_fd = 1'b0;
    end else if (!e) begin
      m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      case (md)
        2'b01: begin m_q = {sr, m_q[7:1]}; adv = 1'b1; end
        2'b10: begin m_q = {m_q[6:0], sl}; adv = 1'b1; end
        2'b11: begin m_q = p; m_cnt = 0; end
        default: ;
      endcase
      if (adv) begin
        if (m_cnt == 7) begin
          m_cnt = 0; m_fd = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic step8(input string tag, input logic r, input logic e,
                       input logic [1:0] md, input logic sr, input logic sl,
                       input logic [7:0] p);
    logic [10:0] got;
    rst8 = r; en8 = e; mode8 = md; sin_r8 = sr; sin_l8 = sl; pin8 = p;
    model8(r, e, md, sr, sl, p);
    exp8_q.push_back({m_q, m_q[0], m_q[7], m_fd});
    @(posedge clk);
    #1;
    if (exp8_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: observed=empty-queue expected=entry", tag);
    end else begin
      got = exp8_q.pop_front();
      check(tag, {pout8, sout_r8, sout_l8, fd8}, got);
    end
  endtask

  initial begin
    // WIDTH=8 instance held in reset during the directed phase
    rst8 = 1'b0; en8 = 1'b0; mode8 = 2'b00; sin_r8 = 1'b0; sin_l8 = 1'b0;
    pin8 = 8'h00;
    m_q = 8'h00; m_cnt = 0; m_fd = 1'b0;

    // ---------------- directed, WIDTH=4 ----------------
    //     tag              rst en  mode   sr    sl    pin      pout     fd
    step4("rst_over_load",  0, 1, 2'b11, 1'b1, 1'b1, 4'b1111, 4'b0000, 0);
    step4("rst_en0",        0, 0, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0000, 0);
    // right shifts from reset, frame pulse on the 4th
    step4("shr_1",          1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1000, 0);
    step4("shr_2",          1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0100, 0);
    step4("shr_3",          1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1010, 0);
    step4("shr_4_done",     1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1101, 1);
    step4("hold_after",     1, 1, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b1101, 0);
    // load then left shifts
    step4("load_1001",      1, 1, 2'b11, 1'b1, 1'b1, 4'b1001, 4'b1001, 0);
    step4("shl_1",          1, 1, 2'b10, 1'b1, 1'b0, 4'b0000, 4'b0010, 0);
    step4("shl_2",          1, 1, 2'b10, 1'b1, 1'b0, 4'b0000, 4'b0100, 0);
    step4("shl_3",          1, 1, 2'b10, 1'b1, 1'b0, 4'b0000, 4'b1000, 0);
    // counter is at its last value: load must win, no pulse
    step4("load_at_wrap",   1, 1, 2'b11, 1'b0, 1'b0, 4'b0110, 4'b0110, 0);
    step4("hold_load",      1, 1, 2'b00, 1'b1, 1'b1, 4'b1111, 4'b0110, 0);
    // partial frame discarded by reset
    step4("pre_rst_1",      1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1011, 0);
    step4("pre_rst_2",      1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0101, 0);
    step4("mid_rst",        0, 0, 2'b01, 1'b1, 1'b1, 4'b1111, 4'b0000, 0);
    step4("post_rst_1",     1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1000, 0);
    step4("post_rst_2",     1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1100, 0);
    step4("post_rst_3",     1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1110, 0);
    step4("post_rst_4",     1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1111, 1);
    // enable gaps inside a frame
    step4("gap_shr_1",      1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0111, 0);
    step4("gap_shr_2",      1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0011, 0);
    step4("en0_a",          1, 0, 2'b01, 1'b1, 1'b1, 4'b0000, 4'b0011, 0);
    step4("en0_b",          1, 0, 2'b10, 1'b1, 1'b1, 4'b0000, 4'b0011, 0);
    step4("en0_c",          1, 0, 2'b01, 1'b1, 1'b1, 4'b0000, 4'b0011, 0);
    step4("en0_load",       1, 0, 2'b11, 1'b1, 1'b1, 4'b1010, 4'b0011, 0);
    step4("gap_shr_3",      1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1001, 0);
    step4("gap_shr_4",      1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1100, 1);
    // eight consecutive shifts: two pulses four cycles apart
    step4("run8_1",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0110, 0);
    step4("run8_2",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0011, 0);
    step4("run8_3",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0001, 0);
    step4("run8_4",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 1);
    step4("run8_5",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 0);
    step4("run8_6",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 0);
    step4("run8_7",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 0);
    step4("run8_8",         1, 1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 1);
    // mixed directions share one frame counter
    step4("mix_shl_1",      1, 1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b0001, 0);
    step4("mix_shr_2",      1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1000, 0);
    step4("mix_shl_3",      1, 1, 2'b10, 1'b1, 1'b0, 4'b0000, 4'b0000, 0);
    step4("mix_shr_4",      1, 1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1000, 1);
    step4("mix_hold",       1, 1, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b1000, 0);

    // park the WIDTH=4 instance
    rst4 = 1'b1; en4 = 1'b0; mode4 = 2'b00; sin_r4 = 1'b0; sin_l4 = 1'b0;
    pin4 = 4'b0000;

    // ---------------- random, WIDTH=8 vs model ----------------
    step8("w8_reset", 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 1000; i++) begin
      step8("w8_rand",
            ($urandom_range(0, 49) != 0),
            ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
